// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the four-way round-robin fifo merger.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned GNT_W   = 2;

  // Requester 3 counts as last served after reset so requester 0 wins first.
  localparam logic [GNT_W-1:0] LAST_GNT_RST = 2'd3;

  function automatic logic [NUM_REQ-1:0] gnt_onehot(input logic [GNT_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last,
  output logic               found,
  output logic [GNT_W-1:0]   idx
);

  logic [GNT_W-1:0] cand_s;
  logic [GNT_W-1:0] idx_s;
  logic             hit_s;
  logic             found_s;

  // Walk offsets 1..NUM_REQ from 'last'; the nearest hit is kept.
  always_comb begin
    cand_s  = last;
    idx_s   = {GNT_W{1'b0}};
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand_s  = last + GNT_W'(k);
      hit_s   = !found_s && req[cand_s];
      idx_s   = hit_s ? cand_s : idx_s;
      found_s = found_s || hit_s;
    end
  end

  assign found = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Merges four source fifos into one downstream fifo with round-robin bursts
// and a two-stage read pipeline (source fifo latency plus output register).
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int dta_width = 8,
  parameter int burst_len = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_empty,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*dta_width-1:0] req_dout,
  output logic [NUM_REQ-1:0]           req_rd_en,
  input  logic                         out_prog_full,
  output logic [dta_width-1:0]         out_dta,
  output logic                         out_wr_en,
  output logic [GNT_W-1:0]             gnt,
  output logic                         busy
);

  localparam logic [3:0] BURST_LEN_C = 4'(burst_len);

  arb_state_e           state_r, state_nxt_s;
  logic [GNT_W-1:0]     gnt_r, gnt_nxt_s;
  logic [GNT_W-1:0]     last_gnt_r, last_nxt_s;
  logic [3:0]           cnt_r, cnt_nxt_s;
  logic                 rd_s;
  logic [NUM_REQ-1:0]   nonempty_s;
  logic                 pick_found_s;
  logic [GNT_W-1:0]     pick_idx_s;

  logic                 p1_vld_r;
  logic [GNT_W-1:0]     p1_idx_r;
  logic                 rd_valid_s;
  logic [dta_width-1:0] rd_word_s;
  logic                 wr_en_r;
  logic [dta_width-1:0] dta_r;

  assign nonempty_s = ~req_empty;

  rr_pick u_rr_pick (
    .req   (nonempty_s),
    .last  (last_gnt_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state, grant selection and read issue.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    last_nxt_s  = last_gnt_r;
    cnt_nxt_s   = cnt_r;
    rd_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && pick_found_s) begin
          state_nxt_s = BURST;
          gnt_nxt_s   = pick_idx_s;
          last_nxt_s  = pick_idx_s;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        rd_s      = !req_empty[gnt_r] && !out_prog_full && (cnt_r < BURST_LEN_C);
        cnt_nxt_s = rd_s ? (cnt_r + 4'd1) : cnt_r;
        // A full quota or a drained source ends the burst; back-pressure alone never does.
        if ((cnt_r >= BURST_LEN_C) || (req_empty[gnt_r] && !rd_s)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign req_rd_en = rd_s ? gnt_onehot(gnt_r) : {NUM_REQ{1'b0}};

  // FSM, grant and burst counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      gnt_r      <= {GNT_W{1'b0}};
      last_gnt_r <= LAST_GNT_RST;
      cnt_r      <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      gnt_r      <= gnt_nxt_s;
      last_gnt_r <= last_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Source data arriving one cycle after the read, selected by the captured index.
  always_comb begin
    rd_valid_s = p1_vld_r && req_valid[p1_idx_r];
    rd_word_s  = req_dout[int'(p1_idx_r)*dta_width +: dta_width];
  end

  // Read pipeline: in-flight words finish regardless of later FSM moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_vld_r <= 1'b0;
      p1_idx_r <= {GNT_W{1'b0}};
      wr_en_r  <= 1'b0;
      dta_r    <= {dta_width{1'b0}};
    end else begin
      p1_vld_r <= rd_s;
      p1_idx_r <= gnt_r;
      wr_en_r  <= rd_valid_s;
      if (rd_valid_s) begin
        dta_r <= rd_word_s;
      end else begin
        dta_r <= dta_r;
      end
    end
  end

  assign out_wr_en = wr_en_r;
  assign out_dta   = dta_r;
  assign gnt       = gnt_r;
  assign busy      = (state_r == BURST);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: source fifos modelled as word logs, a transaction-level
// arbiter model checked every cycle, plus literal per-scenario totals.
module tb_fifo_rr_arbiter;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [3:0]    req_empty;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_dout;
  logic [3:0]    req_rd_en;
  logic          out_prog_full;
  logic [DW-1:0] out_dta;
  logic          out_wr_en;
  logic [1:0]    gnt;
  logic          busy;

  fifo_rr_arbiter #(.dta_width(DW), .burst_len(BL)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .req_empty     (req_empty),
    .req_valid     (req_valid),
    .req_dout      (req_dout),
    .req_rd_en     (req_rd_en),
    .out_prog_full (out_prog_full),
    .out_dta       (out_dta),
    .out_wr_en     (out_wr_en),
    .gnt           (gnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Source fifos: every word ever pushed, plus the read pointer the DUT drives.
  logic [7:0]    hist     [4][64];
  bit            hist_bad [4][64];
  int            hist_n   [4];
  int            env_rp   [4];
  logic [DW-1:0] env_dout [4];
  bit            env_vld  [4];

  // Arbiter model state.
  bit         m_busy;
  int         m_gnt, m_last, m_cnt;
  int         m_rp [4];
  bit         m_v1, m_v2;
  logic [7:0] m_w1, m_w2;
  bit         m_av [4];
  int         e_rd;
  logic [3:0] dut_rd;
  bit         en_s;

  int n_cmp, n_err;
  int rd_total, wr_total, g_n, mark;
  int g_log [16];
  int g_rd  [16];
  bit busy_prev;

  task automatic cmp(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < 4; i++) begin
      req_empty[i]          = !(hist_n[i] > env_rp[i]);
      req_valid[i]          = env_vld[i];
      req_dout[i*DW +: DW]  = env_dout[i];
    end
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_gnt = 0; m_last = 3; m_cnt = 0;
    m_v1 = 1'b0; m_v2 = 1'b0; m_w1 = 8'h00; m_w2 = 8'h00;
  endfunction

  function automatic void push(input int i, input bit bad);
    hist[i][hist_n[i]]     = 8'(i*64 + hist_n[i]);
    hist_bad[i][hist_n[i]] = bad;
    hist_n[i]++;
    drive();
  endfunction

  function automatic void clear_stats();
    rd_total = 0; wr_total = 0; g_n = 0;
  endfunction

  // Mid-cycle: compare DUT against model and collect statistics.
  task automatic check_cycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) m_av[i] = hist_n[i] > env_rp[i];
    e_rd = -1;
    if (rst && m_busy && m_av[m_gnt] && !out_prog_full && m_cnt < BL) e_rd = m_gnt;
    cmp("req_rd_en", int'(req_rd_en), (e_rd >= 0) ? (1 << e_rd) : 0);
    cmp("rd_onehot", int'($countones(req_rd_en) > 1), 0);
    cmp("gnt", int'(gnt), m_gnt);
    cmp("busy", int'(busy), int'(m_busy));
    cmp("out_wr_en", int'(out_wr_en), int'(m_v2));
    if (m_v2) cmp("out_dta", int'(out_dta), int'(m_w2));
    if (busy && !busy_prev && g_n < 16) begin
      g_log[g_n] = int'(gnt);
      g_rd[g_n]  = 0;
      g_n++;
    end
    busy_prev = busy;
    if (req_rd_en != 4'd0) begin
      rd_total++;
      if (g_n > 0) g_rd[g_n-1]++;
    end
    if (out_wr_en) wr_total++;
    dut_rd = req_rd_en;
    en_s   = enable;
  endtask

  // Just after the edge: advance source fifos and the model by one cycle.
  task automatic advance();
    int old_cnt;
    int idx;
    bit found;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      env_vld[i] = 1'b0;
      if (dut_rd[i]) begin
        cmp("no_underflow", int'(hist_n[i] > env_rp[i]), 1);
        if (hist_n[i] > env_rp[i]) begin
          env_dout[i] = hist[i][env_rp[i]];
          env_vld[i]  = !hist_bad[i][env_rp[i]];
          env_rp[i]++;
        end
      end
    end
    if (!rst) begin
      model_reset();
    end else begin
      old_cnt = m_cnt;
      m_v2 = m_v1; m_w2 = m_w1; m_v1 = 1'b0;
      if (e_rd >= 0) begin
        m_w1 = hist[e_rd][m_rp[e_rd]];
        m_v1 = !hist_bad[e_rd][m_rp[e_rd]];
        m_rp[e_rd]++;
        m_cnt++;
      end
      if (!m_busy) begin
        found = 1'b0;
        if (en_s) begin
          for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (!found && m_av[idx]) begin
              found = 1'b1; m_busy = 1'b1; m_gnt = idx; m_last = idx; m_cnt = 0;
            end
          end
        end
      end else if (old_cnt >= BL || (!m_av[m_gnt] && e_rd < 0)) begin
        m_busy = 1'b0;
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      check_cycle();
      advance();
    end
  endtask

  task automatic wait_rd(input int target, input int budget, input string name);
    int b = 0;
    while (rd_total < target && b < budget) begin
      run(1);
      b++;
    end
    cmp(name, int'(rd_total >= target), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      env_rp[i] = hist_n[i]; m_rp[i] = hist_n[i]; env_vld[i] = 1'b0;
    end
    drive();
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; busy_prev = 1'b0; dut_rd = 4'd0;
    enable = 1'b0; out_prog_full = 1'b0; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hist_n[i] = 0; env_rp[i] = 0; m_rp[i] = 0; env_dout[i] = 8'h00; env_vld[i] = 1'b0;
    end
    model_reset();
    clear_stats();
    drive();
    #1 rst = 1'b0;

    // Reset state
    check_cycle();
    cmp("rst_rd_en", int'(req_rd_en), 0);
    cmp("rst_wr_en", int'(out_wr_en), 0);
    cmp("rst_dta", int'(out_dta), 0);
    cmp("rst_gnt", int'(gnt), 0);
    cmp("rst_busy", int'(busy), 0);
    advance();
    run(1);
    rst = 1'b1;

    // Six words everywhere: grants 0..3 twice, bursts 4 then 2
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 6; k++) push(i, 1'b0);
    run(60);
    cmp("s1_writes", wr_total, 24);
    cmp("s1_grants", g_n, 8);
    for (int j = 0; j < 8; j++) begin
      cmp("s1_gnt_seq", g_log[j], j % 4);
      cmp("s1_burst_len", g_rd[j], (j < 4) ? 4 : 2);
    end

    // Only requester 2, three words
    do_reset();
    clear_stats();
    for (int k = 0; k < 3; k++) push(2, 1'b0);
    run(12);
    cmp("s2_grants", g_n, 1);
    cmp("s2_gnt", g_log[0], 2);
    cmp("s2_reads", g_rd[0], 3);
    cmp("s2_writes", wr_total, 3);

    // Back-pressure for 5 cycles after the second read
    do_reset();
    clear_stats();
    for (int k = 0; k < 4; k++) push(0, 1'b0);
    wait_rd(2, 10, "s3_second_read");
    out_prog_full = 1'b1;
    mark = rd_total;
    run(5);
    cmp("s3_stall_reads", rd_total - mark, 0);
    out_prog_full = 1'b0;
    run(12);
    cmp("s3_grants", g_n, 1);
    cmp("s3_reads", g_rd[0], 4);
    cmp("s3_writes", wr_total, 4);

    // Reset one cycle after a read drops the in-flight word
    do_reset();
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0);
      push(1, 1'b0);
    end
    wait_rd(1, 10, "s4_first_read");
    rst = 1'b0;
    model_reset();
    run(1);
    rst = 1'b1;
    clear_stats();
    run(2);
    cmp("s4_no_wr_after_rst", wr_total, 0);
    cmp("s4_gnt", int'(gnt), 0);
    run(25);
    cmp("s4_first_gnt", g_log[0], 0);
    cmp("s4_writes", wr_total, 5);

    // Enable low: no reads; dropping it mid-burst keeps the burst whole
    enable = 1'b0;
    do_reset();
    clear_stats();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 6; k++) push(i, 1'b0);
    run(20);
    cmp("s5_no_reads", rd_total, 0);
    enable = 1'b1;
    wait_rd(1, 10, "s5_first_read");
    enable = 1'b0;
    run(15);
    cmp("s5_grants", g_n, 1);
    cmp("s5_reads", g_rd[0], BL);
    enable = 1'b1;
    run(60);
    cmp("s5_writes", wr_total, 24);

    // A read returning valid low is dropped
    do_reset();
    clear_stats();
    push(1, 1'b1);
    push(1, 1'b0);
    run(12);
    cmp("s6_reads", g_rd[0], 2);
    cmp("s6_writes", wr_total, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
